// File: rtl/mipi_csi_rx_stream_controller.sv
// Frame-level sequencer between the CSI-2 lane aligner and packet decoder.
// Detects FS/FE short packets on the first word of each burst, gates the
// decoder valid to requested frames only, counts lines per frame and keeps
// sticky length and framing error flags.
module mipi_csi_rx_stream_controller #(
    parameter int LANES     = 4,
    parameter int MIPI_GEAR = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         enable_i,
    input  logic [7:0]                   frame_count_i,
    input  logic [15:0]                  expected_length_i,
    input  logic                         clear_errors_i,
    input  logic                         data_valid_i,
    input  logic [LANES*MIPI_GEAR-1:0]   data_i,
    output logic [LANES*MIPI_GEAR-1:0]   data_o,
    output logic                         decoder_valid_o,
    input  logic                         decoder_output_valid_i,
    input  logic [15:0]                  decoder_packet_length_i,
    output logic                         frame_valid_o,
    output logic                         line_valid_o,
    output logic [15:0]                  line_count_o,
    output logic [15:0]                  last_line_count_o,
    output logic                         frame_done_o,
    output logic                         busy_o,
    output logic                         length_error_o,
    output logic                         sync_error_o
);

    localparam int         DATA_W  = LANES * MIPI_GEAR;
    localparam logic [7:0] SP_SYNC = 8'hB8;
    localparam logic [7:0] DT_FS   = 8'h00;
    localparam logic [7:0] DT_FE   = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_prev_valid;
    logic                r_prev_dout_valid;
    logic                r_continuous;
    logic [7:0]          r_frames_left;
    logic [DATA_W-1:0]   r_data_p1;
    logic                r_dec_valid_p1;
    logic                r_line_valid;
    logic [15:0]         r_line_count;
    logic [15:0]         r_last_line_count;
    logic                r_frame_done;
    logic                r_length_error;
    logic                r_sync_error;

    logic w_first_word;
    logic w_is_fs;
    logic w_is_fe;
    logic w_active;
    logic w_line_edge;
    logic w_len_mismatch;
    logic w_load;
    logic w_start_frame;
    logic w_restart_frame;
    logic w_end_frame;
    logic w_sync_set;

    // Only the first word of a burst can be a short-packet header; payload
    // words that happen to match the FS/FE pattern are ignored.
    assign w_first_word   = data_valid_i & ~r_prev_valid;
    assign w_is_fs        = w_first_word && (data_i[7:0] == SP_SYNC) && (data_i[15:8] == DT_FS);
    assign w_is_fe        = w_first_word && (data_i[7:0] == SP_SYNC) && (data_i[15:8] == DT_FE);
    assign w_active       = (r_state == ST_ACTIVE);
    assign w_line_edge    = decoder_output_valid_i & ~r_prev_dout_valid & w_active;
    assign w_len_mismatch = w_line_edge && (expected_length_i != 16'd0) &&
                            (decoder_packet_length_i != expected_length_i);

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= ST_IDLE;
        else            r_state <= w_state_next;
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        w_state_next    = r_state;
        w_load          = 1'b0;
        w_start_frame   = 1'b0;
        w_restart_frame = 1'b0;
        w_end_frame     = 1'b0;
        w_sync_set      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable_i) begin
                    w_state_next = ST_ARMED;
                    w_load       = 1'b1;
                end
            end
            ST_ARMED: begin
                if (w_is_fe) w_sync_set = 1'b1;
                if (!enable_i) begin
                    w_state_next = ST_IDLE;
                end else if (w_is_fs) begin
                    w_state_next  = ST_ACTIVE;
                    w_start_frame = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_is_fe) begin
                    w_end_frame = 1'b1;
                    if (r_continuous && enable_i)                 w_state_next = ST_ARMED;
                    else if (!r_continuous && r_frames_left == 8'd1) w_state_next = ST_DONE;
                    else if (!enable_i)                           w_state_next = ST_IDLE;
                    else                                          w_state_next = ST_ARMED;
                end else if (w_is_fs) begin
                    // Missing FE: restart the frame without counting it.
                    w_sync_set      = 1'b1;
                    w_restart_frame = 1'b1;
                end
            end
            ST_DONE: begin
                if (!enable_i) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // One-cycle datapath: data always forwarded, valid gated to ACTIVE.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_prev_valid      <= 1'b0;
            r_prev_dout_valid <= 1'b0;
            r_data_p1         <= '0;
            r_dec_valid_p1    <= 1'b0;
            r_line_valid      <= 1'b0;
        end else begin
            r_prev_valid      <= data_valid_i;
            r_prev_dout_valid <= decoder_output_valid_i;
            r_data_p1         <= data_i;
            r_dec_valid_p1    <= data_valid_i & w_active;
            r_line_valid      <= decoder_output_valid_i & w_active;
        end
    end

    // Capture mode: frame budget loaded on arming, consumed per completed frame.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_frames_left <= 8'd0;
            r_continuous  <= 1'b0;
        end else if (w_load) begin
            r_frames_left <= frame_count_i;
            r_continuous  <= (frame_count_i == 8'd0);
        end else if (w_end_frame && !r_continuous) begin
            r_frames_left <= r_frames_left - 8'd1;
        end
    end

    // Line counter (saturating), last-frame latch and frame-done pulse.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_line_count      <= 16'd0;
            r_last_line_count <= 16'd0;
            r_frame_done      <= 1'b0;
        end else begin
            r_frame_done <= w_end_frame;
            if (w_end_frame) r_last_line_count <= r_line_count;
            if (w_start_frame || w_restart_frame)
                r_line_count <= 16'd0;
            else if (w_line_edge && r_line_count != 16'hFFFF)
                r_line_count <= r_line_count + 16'd1;
        end
    end

    // Sticky error flags; a new error in the clear cycle wins.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_length_error <= 1'b0;
            r_sync_error   <= 1'b0;
        end else begin
            if (w_len_mismatch)      r_length_error <= 1'b1;
            else if (clear_errors_i) r_length_error <= 1'b0;
            if (w_sync_set)          r_sync_error   <= 1'b1;
            else if (clear_errors_i) r_sync_error   <= 1'b0;
        end
    end

    assign data_o            = r_data_p1;
    assign decoder_valid_o   = r_dec_valid_p1;
    assign frame_valid_o     = w_active;
    assign line_valid_o      = r_line_valid;
    assign line_count_o      = r_line_count;
    assign last_line_count_o = r_last_line_count;
    assign frame_done_o      = r_frame_done;
    assign busy_o            = (r_state != ST_IDLE);
    assign length_error_o    = r_length_error;
    assign sync_error_o      = r_sync_error;

endmodule

// File: tb/tb_mipi_csi_rx_stream_controller.sv
// Bench for mipi_csi_rx_stream_controller: directed capture scenarios
// followed by randomized packet traffic, every cycle compared against a
// frame-level behavioural model.
module tb_mipi_csi_rx_stream_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [7:0]  frame_count;
    logic [15:0] expected_length;
    logic        clear_errors;
    logic        data_valid;
    logic [31:0] data;
    logic        dov;
    logic [15:0] plen;

    logic [31:0] data_o;
    logic        decoder_valid_o;
    logic        frame_valid_o;
    logic        line_valid_o;
    logic [15:0] line_count_o;
    logic [15:0] last_line_count_o;
    logic        frame_done_o;
    logic        busy_o;
    logic        length_error_o;
    logic        sync_error_o;

    mipi_csi_rx_stream_controller #(.LANES(4), .MIPI_GEAR(8)) dut (
        .clk_i                   (clk),
        .reset_n_i               (reset_n),
        .enable_i                (enable),
        .frame_count_i           (frame_count),
        .expected_length_i       (expected_length),
        .clear_errors_i          (clear_errors),
        .data_valid_i            (data_valid),
        .data_i                  (data),
        .data_o                  (data_o),
        .decoder_valid_o         (decoder_valid_o),
        .decoder_output_valid_i  (dov),
        .decoder_packet_length_i (plen),
        .frame_valid_o           (frame_valid_o),
        .line_valid_o            (line_valid_o),
        .line_count_o            (line_count_o),
        .last_line_count_o       (last_line_count_o),
        .frame_done_o            (frame_done_o),
        .busy_o                  (busy_o),
        .length_error_o          (length_error_o),
        .sync_error_o            (sync_error_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    endtask

    // Frame-level model: "requested", "inside a frame", "capture finished"
    // and a remaining-frame budget, evolved by the header/line rules.
    bit          m_armed, m_in_frame, m_finished, m_cont;
    int          m_left;
    bit          m_prev_v, m_prev_dov;
    int          m_lines, m_last;
    bit          m_done, m_lerr, m_serr, m_dv, m_lv;
    logic [31:0] m_data;
    int          exp_done_count = 0;
    int          dut_done_count = 0;

    function automatic void model_reset();
        m_armed = 0; m_in_frame = 0; m_finished = 0; m_cont = 0; m_left = 0;
        m_prev_v = 0; m_prev_dov = 0; m_lines = 0; m_last = 0;
        m_done = 0; m_lerr = 0; m_serr = 0; m_dv = 0; m_lv = 0; m_data = 32'd0;
    endfunction

    function automatic void model_step();
        bit hdr, fs, fe, act, line_edge, set_s, set_l, clr_lines;
        act       = m_in_frame;
        hdr       = data_valid && !m_prev_v;
        fs        = hdr && (data[15:0] == 16'h00B8);
        fe        = hdr && (data[15:0] == 16'h01B8);
        line_edge = dov && !m_prev_dov && act;
        set_l     = line_edge && (expected_length != 16'd0) && (plen != expected_length);
        set_s     = 0;
        clr_lines = 0;
        m_done    = 0;
        m_dv      = data_valid && act;
        m_lv      = dov && act;
        m_data    = data;
        if (m_in_frame) begin
            if (fe) begin
                m_done = 1;
                exp_done_count++;
                m_last = m_lines;
                m_in_frame = 0;
                if (m_cont) m_armed = enable;
                else begin
                    m_left--;
                    if (m_left == 0) m_finished = 1;
                    else m_armed = enable;
                end
            end else if (fs) begin
                set_s = 1;
                clr_lines = 1;
            end
        end else if (m_finished) begin
            if (!enable) m_finished = 0;
        end else if (m_armed) begin
            if (fe) set_s = 1;
            if (!enable) m_armed = 0;
            else if (fs) begin
                m_armed = 0;
                m_in_frame = 1;
                clr_lines = 1;
            end
        end else if (enable) begin
            m_armed = 1;
            m_left  = int'(frame_count);
            m_cont  = (frame_count == 8'd0);
        end
        if (clr_lines) m_lines = 0;
        else if (line_edge && m_lines < 65535) m_lines++;
        if (set_s) m_serr = 1; else if (clear_errors) m_serr = 0;
        if (set_l) m_lerr = 1; else if (clear_errors) m_lerr = 0;
        m_prev_v   = data_valid;
        m_prev_dov = dov;
    endfunction

    task automatic check_all();
        if (frame_done_o) dut_done_count++;
        chk("data_o",            data_o,                 m_data);
        chk("decoder_valid",     32'(decoder_valid_o),   32'(m_dv));
        chk("frame_valid",       32'(frame_valid_o),     32'(m_in_frame));
        chk("line_valid",        32'(line_valid_o),      32'(m_lv));
        chk("line_count",        32'(line_count_o),      32'(m_lines));
        chk("last_line_count",   32'(last_line_count_o), 32'(m_last));
        chk("frame_done",        32'(frame_done_o),      32'(m_done));
        chk("busy",              32'(busy_o),            32'(m_armed | m_in_frame | m_finished));
        chk("length_error",      32'(length_error_o),    32'(m_lerr));
        chk("sync_error",        32'(sync_error_o),      32'(m_serr));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        data_valid = 0;
        dov = 0;
        repeat (n) cycle();
    endtask

    task automatic short_pkt(input logic [7:0] dt);
        logic [31:0] r;
        r = $urandom();
        data_valid = 1;
        data = {r[31:16], dt, 8'hB8};
        cycle();
        data_valid = 0;
        cycle();
    endtask

    // Long packet: header word, then payload words while the emulated
    // decoder reports payload valid; optional FE-lookalike payload word.
    task automatic line(input logic [15:0] len, input int nwords, input bit alias_fe);
        logic [31:0] r;
        r = $urandom();
        data_valid = 1;
        dov = 0;
        data = {r[31:16], 8'h00, 8'h2B};
        cycle();
        for (int i = 0; i < nwords; i++) begin
            r = $urandom();
            data = (alias_fe && i == 0) ? {r[31:16], 16'h01B8} : r;
            dov  = 1;
            plen = len;
            cycle();
        end
        data_valid = 0;
        dov = 0;
        cycle();
    endtask

    int d0;

    initial begin
        reset_n = 1; enable = 0; frame_count = 0; expected_length = 0;
        clear_errors = 0; data_valid = 0; data = 0; dov = 0; plen = 0;
        #1 reset_n = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1;
        idle(2);

        // Single frame with pre-FS long packets.
        frame_count = 8'd1; expected_length = 16'd640; enable = 1;
        idle(1);
        line(16'd640, 3, 0);
        line(16'd640, 3, 0);
        chk("prefs_line_count", 32'(line_count_o), 32'd0);
        d0 = dut_done_count;
        short_pkt(8'h00);
        chk("single_frame_valid", 32'(frame_valid_o), 32'd1);
        for (int i = 0; i < 3; i++) line(16'd640, 4, 0);
        short_pkt(8'h01);
        chk("single_lines", 32'(last_line_count_o), 32'd3);
        chk("single_done_cnt", 32'(dut_done_count - d0), 32'd1);
        chk("single_busy_done", 32'(busy_o), 32'd1);
        chk("single_no_lerr", 32'(length_error_o), 32'd0);
        enable = 0;
        idle(2);
        chk("single_idle", 32'(busy_o), 32'd0);

        // N-frame capture: third frame must not be forwarded.
        frame_count = 8'd2; enable = 1;
        idle(1);
        d0 = dut_done_count;
        for (int f = 0; f < 3; f++) begin
            short_pkt(8'h00);
            line(16'd640, 3, 0);
            line(16'd640, 3, 0);
            short_pkt(8'h01);
        end
        chk("nframe_done_cnt", 32'(dut_done_count - d0), 32'd2);
        enable = 0;
        idle(2);

        // Continuous capture with graceful stop.
        frame_count = 8'd0; enable = 1;
        idle(1);
        short_pkt(8'h00);
        line(16'd640, 2, 0);
        short_pkt(8'h01);
        short_pkt(8'h00);
        line(16'd640, 2, 0);
        enable = 0;
        line(16'd640, 2, 0);
        chk("cont_still_active", 32'(frame_valid_o), 32'd1);
        short_pkt(8'h01);
        chk("cont_stopped", 32'(busy_o), 32'd0);
        chk("cont_last_lines", 32'(last_line_count_o), 32'd2);

        // Error flags.
        frame_count = 8'd0; expected_length = 16'd640; enable = 1;
        idle(1);
        short_pkt(8'h00);
        line(16'd636, 2, 0);
        chk("len_err_set", 32'(length_error_o), 32'd1);
        short_pkt(8'h00);
        chk("sync_err_fs", 32'(sync_error_o), 32'd1);
        chk("sync_restart_lines", 32'(line_count_o), 32'd0);
        line(16'd640, 2, 0);
        short_pkt(8'h01);
        clear_errors = 1;
        cycle();
        clear_errors = 0;
        chk("clear_len", 32'(length_error_o), 32'd0);
        chk("clear_sync", 32'(sync_error_o), 32'd0);
        short_pkt(8'h01);
        chk("sync_err_fe_armed", 32'(sync_error_o), 32'd1);
        clear_errors = 1;
        cycle();
        clear_errors = 0;

        // Payload aliasing, then asynchronous reset mid-frame.
        short_pkt(8'h00);
        line(16'd640, 4, 1);
        chk("alias_active", 32'(frame_valid_o), 32'd1);
        chk("alias_lines", 32'(line_count_o), 32'd1);
        data_valid = 1; data = 32'h1234_002B; cycle();
        data = $urandom(); dov = 1; plen = 16'd640; cycle();
        reset_n = 0; data_valid = 0; dov = 0;
        #1;
        chk("rst_data_o", data_o, 32'd0);
        chk("rst_dec_valid", 32'(decoder_valid_o), 32'd0);
        chk("rst_frame_valid", 32'(frame_valid_o), 32'd0);
        chk("rst_line_count", 32'(line_count_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_line_valid", 32'(line_valid_o), 32'd0);
        model_reset();
        #2 reset_n = 1;
        idle(2);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 11))
                0, 1:       short_pkt(8'h00);
                2:          short_pkt(8'h01);
                3, 4, 5, 6: line(($urandom_range(0, 3) == 0) ? 16'd636 : 16'd640,
                                 int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
                7:          idle(int'($urandom_range(1, 3)));
                8, 9: begin
                    enable = ~enable;
                    frame_count = 8'($urandom_range(0, 3));
                    expected_length = ($urandom_range(0, 1) == 1) ? 16'd640 : 16'd0;
                    idle(1);
                end
                default: begin
                    clear_errors = 1;
                    idle(1);
                    clear_errors = 0;
                end
            endcase
        end
        enable = 0;
        idle(3);
        chk("done_total", 32'(dut_done_count), 32'(exp_done_count));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mipi_csi_rx_stream_controller.md
# mipi_csi_rx_stream_controller

Frame-level sequencer sitting between the lane aligner and the CSI-2 packet decoder. It detects Frame Start and Frame End short packets on the lane-aligned 32-bit stream and arms the decoder's `data_valid` only inside frames the host asked for. It runs single-shot, N-frame or continuous capture and reports frame and line status upward. It also counts lines per frame and flags length and framing errors.

## Interface
- `LANES`, 4: CSI-2 lane count; fixed at 4 in this design.
- `MIPI_GEAR`, 8: bits per lane per byte clock.
- `clk_i`  in  1: MIPI byte clock; same clock as the aligner and decoder.
- `reset_n_i`  in  1: asynchronous, active-low reset.
- `enable_i`  in  1: capture request, level-sensitive.
- `frame_count_i`  in  8: number of frames to capture; 0 means continuous.
- `expected_length_i`  in  16: expected long-packet word count in bytes; 0 disables the length check.
- `clear_errors_i`  in  1: one-cycle pulse that clears the sticky error flags.
- `data_valid_i`  in  1: aligned-data valid from the lane aligner.
- `data_i`  in  32: aligned data; byte 0 is `[7:0]`.
- `data_o`  out  32: `data_i` delayed by one cycle, feeds the decoder.
- `decoder_valid_o`  out  1: gated valid to the decoder, aligned with `data_o`.
- `decoder_output_valid_i`  in  1: payload-valid signal from the decoder.
- `decoder_packet_length_i`  in  16: packet length from the decoder.
- `frame_valid_o`  out  1: high while the block is inside a frame (state ACTIVE).
- `line_valid_o`  out  1: registered `decoder_output_valid_i & frame_valid_o`.
- `line_count_o`  out  16: lines seen so far in the current frame.
- `last_line_count_o`  out  16: line count latched at the last Frame End.
- `frame_done_o`  out  1: one-cycle pulse per completed frame.
- `busy_o`  out  1: state is not IDLE.
- `length_error_o`  out  1: sticky length mismatch flag.
- `sync_error_o`  out  1: sticky framing error flag.

## Operation
- **Header qualification:**
  - Only the first word of a burst is treated as a header, i.e. `data_valid_i` high with its previous-cycle value low.
  - Frame Start (FS) = `data_i[7:0]==8'hB8 && data_i[15:8]==8'h00`.
  - Frame End (FE) = the same test with `data_i[15:8]==8'h01`.
  - Identical byte patterns inside a payload are ignored.
- **States:** IDLE, ARMED, ACTIVE, DONE.
  - IDLE → ARMED when `enable_i` is high. At this transition, load `frames_left` from `frame_count_i` and set `continuous` = (`frame_count_i==0`).
  - ARMED → ACTIVE on FS. Clear `line_count_o`.
  - ARMED with `enable_i` low → IDLE.
  - ARMED receiving FE → stay in ARMED, set `sync_error_o`.
  - ACTIVE receiving FE:
    - Pulse `frame_done_o` and latch `last_line_count_o` from `line_count_o`.
    - If not `continuous`, decrement `frames_left`.
    - If `continuous` and `enable_i` is high → ARMED.
    - If not `continuous` and `frames_left` was 1 → DONE.
    - If `enable_i` is low → IDLE (graceful stop: a frame in progress always runs to its FE).
    - Otherwise → ARMED.
  - ACTIVE receiving FS (missing FE): set `sync_error_o`, clear `line_count_o`, stay in ACTIVE. No `frame_done_o` and no decrement.
  - DONE → IDLE when `enable_i` is low. A new capture therefore requires `enable_i` to be dropped and re-raised.
- **Gating:** `decoder_valid_o <= data_valid_i && state==ACTIVE`. FS/FE bursts outside ACTIVE are never forwarded; the FE burst that ends ACTIVE is forwarded, which is harmless to the decoder. `data_o <= data_i` every cycle.
- **Lines:**
  - Each rising edge of `decoder_output_valid_i` while in ACTIVE increments `line_count_o`. The counter saturates at 16'hFFFF.
  - On that same edge, if `expected_length_i != 0` and `decoder_packet_length_i != expected_length_i`, set `length_error_o`.
- **Errors:** both flags are sticky. They clear only on `clear_errors_i` or reset. A set event and `clear_errors_i` in the same cycle leave the flag set.

## Timing
- Reset values:
  - State = IDLE.
  - `data_o`, `line_count_o`, `last_line_count_o` = 0.
  - All 1-bit outputs = 0.
  - `frames_left` = 0, `continuous` = 0.
  - The previous-cycle valid register = 0.
- Datapath latency: one cycle. Data and valid are both registered, so `data_o` and `decoder_valid_o` stay aligned.
- For an FS or FE header at cycle t:
  - State, `frame_valid_o` and `frame_done_o` update at t+1.
  - The first payload word forwarded is the first valid word after t.
- Line and error outputs update one cycle after the `decoder_output_valid_i` edge. `line_valid_o` lags `decoder_output_valid_i` by one cycle.
- `enable_i` changes take effect on the next state evaluation. Dropping `enable_i` in ACTIVE has no effect until FE.
- Asserting `reset_n_i` mid-frame immediately returns all state and outputs to their reset values, including `decoder_valid_o`.

## Test plan
- **Single frame.** `frame_count_i=1`, `enable_i=1`, then FS, 3 long packets of 640 B (`expected_length_i=640`), FE → `frame_valid_o` high from FS+1 to FE+1. Expect `line_count_o=3`, one `frame_done_o` pulse, `last_line_count_o=3`, state DONE, no errors. Then `enable_i=0` → IDLE.
- **Pre-FS data.** Long packets before FS → `decoder_valid_o` stays 0 and `line_count_o` stays 0.
- **N-frame capture.** `frame_count_i=2`, 3 frames sent → exactly 2 `frame_done_o` pulses; the third frame is not forwarded.
- **Continuous with graceful stop.** `frame_count_i=0`; drop `enable_i` mid-frame → forwarding continues until FE, then IDLE with `busy_o=0`.
- **Errors.**
  - A 636 B line with `expected_length_i=640` → `length_error_o=1`.
  - FS during ACTIVE → `sync_error_o=1` and the line count restarts.
  - FE while ARMED → `sync_error_o=1`.
  - `clear_errors_i` → both flags return to 0.
- **Payload aliasing and reset.** 0xB8,0x01 inside a payload word → no state change. Asserting `reset_n_i` low mid-frame → all outputs 0 within the same cycle (asynchronous reset).
